// File: rtl/rptr_empty_if.sv
// Read-side FIFO pointer bundle: read request and async write pointer in, address/pointer/flags out.
// The block connects through the slave modport; the reader/driver side uses master.
interface rptr_empty_if #(
    parameter int ADDRSIZE = 4
);
    logic                rinc;
    logic [ADDRSIZE:0]   rwptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   rlevel;

    modport master (
        output rinc, rwptr,
        input  raddr, rptr, rempty, ralmost_empty, rlevel
    );

    modport slave (
        input  rinc, rwptr,
        output raddr, rptr, rempty, ralmost_empty, rlevel
    );
endinterface

// File: rtl/rptr_empty.sv
// Read pointer, empty/almost-empty flags and fill level for the dual-clock FIFO read domain.
// Define RPTR_SYNC3_EN for a 3-flop write-pointer synchronizer (default is 2 flops).
module rptr_empty #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input logic          rclk,
    input logic          rrst,
    rptr_empty_if.slave  rif
);

`ifdef RPTR_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE+1)'(AE_THRESH);

    logic [ADDRSIZE:0] wptrSync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] wbin_s;

    logic [ADDRSIZE:0] rbin_q,  rbin_d;
    logic [ADDRSIZE:0] rgray_q, rgray_d;
    logic [ADDRSIZE:0] rlevel_q, rlevel_d;
    logic              rempty_q, rempty_d;
    logic              ralmostEmpty_q, ralmostEmpty_d;
    logic              readEn;

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wptrSync_q[i] <= '0;
            end
        end else begin
            wptrSync_q[0] <= rif.rwptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wptrSync_q[i] <= wptrSync_q[i-1];
            end
        end
    end

    assign rq2_wptr = wptrSync_q[SYNC_STAGES-1];

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        wbin_s[ADDRSIZE] = rq2_wptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
        end
    end

    always_comb begin
        readEn         = rif.rinc & ~rempty_q;
        rbin_d         = rbin_q + {{ADDRSIZE{1'b0}}, readEn};
        rgray_d        = (rbin_d >> 1) ^ rbin_d;
        rlevel_d       = wbin_s - rbin_d;
        rempty_d       = (rgray_d == rq2_wptr);
        ralmostEmpty_d = (rlevel_d <= AE_LIMIT);
    end

    // Flags come from next-state pointers so a read and a fresh write pointer on one edge never glitch empty.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            rbin_q         <= '0;
            rgray_q        <= '0;
            rlevel_q       <= '0;
            rempty_q       <= 1'b1;
            ralmostEmpty_q <= 1'b1;
        end else begin
            rbin_q         <= rbin_d;
            rgray_q        <= rgray_d;
            rlevel_q       <= rlevel_d;
            rempty_q       <= rempty_d;
            ralmostEmpty_q <= ralmostEmpty_d;
        end
    end

    assign rif.raddr         = rbin_q[ADDRSIZE-1:0];
    assign rif.rptr          = rgray_q;
    assign rif.rempty        = rempty_q;
    assign rif.ralmost_empty = ralmostEmpty_q;
    assign rif.rlevel        = rlevel_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Directed self-checking bench for rptr_empty (ADDRSIZE=4, AE_THRESH=2); honours RPTR_SYNC3_EN latency.
module tb_rptr_empty;

`ifdef RPTR_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic rrst;
    int   tests;
    int   fails;

    rptr_empty_if #(.ADDRSIZE(4)) rif ();

    rptr_empty #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
        .rclk (clk),
        .rrst (rrst),
        .rif  (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic inc, input logic [4:0] wptr);
        @(negedge clk);
        rif.rinc  = inc;
        rif.rwptr = wptr;
    endtask

    task automatic test_reset_initial();
        tests++;
        if ({rif.rempty, rif.ralmost_empty, rif.rptr, rif.raddr, rif.rlevel} !== {1'b1, 1'b1, 5'd0, 4'd0, 5'd0}) begin
            $display("[TB] FAIL reset_initial: got e=%b ae=%b rptr=%b raddr=%0d lvl=%0d, want e=1 ae=1 rptr=0 raddr=0 lvl=0",
                     rif.rempty, rif.ralmost_empty, rif.rptr, rif.raddr, rif.rlevel);
            fails++;
        end
    endtask

    task automatic test_underflow();
        drive(1'b1, 5'b00000);
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({rif.raddr, rif.rptr, rif.rempty} !== {4'd0, 5'd0, 1'b1}) begin
                $display("[TB] FAIL underflow[%0d]: got raddr=%0d rptr=%b e=%b, want raddr=0 rptr=0 e=1",
                         i, rif.raddr, rif.rptr, rif.rempty);
                fails++;
            end
        end
        drive(1'b0, 5'b00000);
    endtask

    task automatic test_fill_drain();
        logic [3:0] expAddr [3];
        logic [4:0] expLvl  [3];
        logic       expAe   [3];
        logic       expE    [3];
        expAddr = '{4'd1, 4'd2, 4'd3};
        expLvl  = '{5'd2, 5'd1, 5'd0};
        expAe   = '{1'b1, 1'b1, 1'b1};
        expE    = '{1'b0, 1'b0, 1'b1};
        drive(1'b0, 5'b00010);
        for (int i = 1; i < LAT; i++) tick();
        tests++;
        if (rif.rempty !== 1'b1) begin
            $display("[TB] FAIL fill_early: rempty=%b before latency, want 1", rif.rempty);
            fails++;
        end
        tick();
        tests++;
        if ({rif.rempty, rif.rlevel, rif.ralmost_empty} !== {1'b0, 5'd3, 1'b0}) begin
            $display("[TB] FAIL fill_latency: got e=%b lvl=%0d ae=%b, want e=0 lvl=3 ae=0",
                     rif.rempty, rif.rlevel, rif.ralmost_empty);
            fails++;
        end
        drive(1'b1, 5'b00010);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({rif.raddr, rif.rlevel, rif.ralmost_empty, rif.rempty} !== {expAddr[i], expLvl[i], expAe[i], expE[i]}) begin
                $display("[TB] FAIL drain[%0d]: got raddr=%0d lvl=%0d ae=%b e=%b, want raddr=%0d lvl=%0d ae=%b e=%b",
                         i, rif.raddr, rif.rlevel, rif.ralmost_empty, rif.rempty, expAddr[i], expLvl[i], expAe[i], expE[i]);
                fails++;
            end
        end
        tests++;
        if (rif.rptr !== 5'b00010) begin
            $display("[TB] FAIL drain_rptr: got rptr=%b, want 00010", rif.rptr);
            fails++;
        end
        drive(1'b0, 5'b00010);
    endtask

    task automatic test_almost_empty();
        logic [4:0] expLvl [4];
        logic       expAe  [4];
        expLvl = '{5'd3, 5'd2, 5'd1, 5'd0};
        expAe  = '{1'b0, 1'b1, 1'b1, 1'b1};
        drive(1'b0, 5'b00100);
        for (int i = 0; i < LAT; i++) tick();
        tests++;
        if ({rif.rlevel, rif.ralmost_empty} !== {5'd4, 1'b0}) begin
            $display("[TB] FAIL ae_start: got lvl=%0d ae=%b, want lvl=4 ae=0", rif.rlevel, rif.ralmost_empty);
            fails++;
        end
        drive(1'b1, 5'b00100);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({rif.rlevel, rif.ralmost_empty} !== {expLvl[i], expAe[i]}) begin
                $display("[TB] FAIL ae_step[%0d]: got lvl=%0d ae=%b, want lvl=%0d ae=%b",
                         i, rif.rlevel, rif.ralmost_empty, expLvl[i], expAe[i]);
                fails++;
            end
        end
        tests++;
        if ({rif.rempty, rif.raddr} !== {1'b1, 4'd7}) begin
            $display("[TB] FAIL ae_end: got e=%b raddr=%0d, want e=1 raddr=7", rif.rempty, rif.raddr);
            fails++;
        end
        drive(1'b0, 5'b00100);
    endtask

    task automatic test_reset_midstream();
        // gray(12) with rbin=7 gives level 5
        drive(1'b0, 5'b01010);
        for (int i = 0; i < LAT; i++) tick();
        tests++;
        if (rif.rlevel !== 5'd5) begin
            $display("[TB] FAIL reset_pre: got lvl=%0d, want 5", rif.rlevel);
            fails++;
        end
        @(negedge clk);
        rif.rinc = 1'b1;
        #2;
        rrst = 1'b0;
        #1;
        tests++;
        if ({rif.rempty, rif.ralmost_empty, rif.rptr, rif.raddr, rif.rlevel} !== {1'b1, 1'b1, 5'd0, 4'd0, 5'd0}) begin
            $display("[TB] FAIL reset_async: got e=%b ae=%b rptr=%b raddr=%0d lvl=%0d, want 1 1 0 0 0",
                     rif.rempty, rif.ralmost_empty, rif.rptr, rif.raddr, rif.rlevel);
            fails++;
        end
        rif.rwptr = 5'b00000;
        tick();
        drive(1'b0, 5'b00000);
        rrst = 1'b1;
        for (int i = 0; i < LAT + 1; i++) tick();
        tests++;
        if ({rif.rempty, rif.ralmost_empty, rif.rptr, rif.raddr, rif.rlevel} !== {1'b1, 1'b1, 5'd0, 4'd0, 5'd0}) begin
            $display("[TB] FAIL reset_hold: got e=%b ae=%b rptr=%b raddr=%0d lvl=%0d, want 1 1 0 0 0",
                     rif.rempty, rif.ralmost_empty, rif.rptr, rif.raddr, rif.rlevel);
            fails++;
        end
    endtask

    task automatic test_full_wrap();
        logic [3:0] expAddr;
        drive(1'b0, 5'b11000);
        for (int i = 0; i < LAT; i++) tick();
        tests++;
        if ({rif.rlevel, rif.rempty, rif.ralmost_empty} !== {5'd16, 1'b0, 1'b0}) begin
            $display("[TB] FAIL full: got lvl=%0d e=%b ae=%b, want lvl=16 e=0 ae=0", rif.rlevel, rif.rempty, rif.ralmost_empty);
            fails++;
        end
        drive(1'b1, 5'b11000);
        for (int i = 1; i <= 16; i++) begin
            tick();
            expAddr = 4'(i);
            tests++;
            if (rif.raddr !== expAddr) begin
                $display("[TB] FAIL wrap_addr[%0d]: got raddr=%0d, want %0d", i, rif.raddr, expAddr);
                fails++;
            end
        end
        tests++;
        if ({rif.rptr, rif.rempty, rif.rlevel} !== {5'b11000, 1'b1, 5'd0}) begin
            $display("[TB] FAIL wrap_end: got rptr=%b e=%b lvl=%0d, want rptr=11000 e=1 lvl=0", rif.rptr, rif.rempty, rif.rlevel);
            fails++;
        end
        drive(1'b0, 5'b11110);
        for (int i = 1; i < LAT; i++) tick();
        tests++;
        if ({rif.rlevel, rif.rempty} !== {5'd0, 1'b1}) begin
            $display("[TB] FAIL wrap_early: got lvl=%0d e=%b, want lvl=0 e=1", rif.rlevel, rif.rempty);
            fails++;
        end
        tick();
        tests++;
        if ({rif.rlevel, rif.rempty} !== {5'd4, 1'b0}) begin
            $display("[TB] FAIL wrap_refill: got lvl=%0d e=%b, want lvl=4 e=0", rif.rlevel, rif.rempty);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        // read three of four words, then a read lands with the next write pointer
        drive(1'b1, 5'b11110);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, 5'b11111);
        tests++;
        if ({rif.rlevel, rif.rempty} !== {5'd1, 1'b0}) begin
            $display("[TB] FAIL b2b_pre: got lvl=%0d e=%b, want lvl=1 e=0", rif.rlevel, rif.rempty);
            fails++;
        end
        for (int i = 1; i < LAT; i++) begin
            tick();
            tests++;
            if ({rif.rlevel, rif.rempty} !== {5'd1, 1'b0}) begin
                $display("[TB] FAIL b2b_wait[%0d]: got lvl=%0d e=%b, want lvl=1 e=0", i, rif.rlevel, rif.rempty);
                fails++;
            end
        end
        drive(1'b1, 5'b11111);
        tick();
        tests++;
        if ({rif.rlevel, rif.rempty, rif.raddr} !== {5'd1, 1'b0, 4'd4}) begin
            $display("[TB] FAIL b2b_concurrent: got lvl=%0d e=%b raddr=%0d, want lvl=1 e=0 raddr=4",
                     rif.rlevel, rif.rempty, rif.raddr);
            fails++;
        end
        tick();
        tests++;
        if ({rif.rlevel, rif.rempty, rif.raddr, rif.rptr} !== {5'd0, 1'b1, 4'd5, 5'b11111}) begin
            $display("[TB] FAIL b2b_last: got lvl=%0d e=%b raddr=%0d rptr=%b, want lvl=0 e=1 raddr=5 rptr=11111",
                     rif.rlevel, rif.rempty, rif.raddr, rif.rptr);
            fails++;
        end
        drive(1'b0, 5'b11111);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rrst      = 1'b0;
        rif.rinc  = 1'b0;
        rif.rwptr = 5'b00000;
        tick();
        tick();
        test_reset_initial();
        @(negedge clk);
        rrst = 1'b1;
        test_underflow();
        test_fill_drain();
        test_almost_empty();
        test_reset_midstream();
        test_full_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
- Read-side pointer and empty-flag controller for the dual-clock FIFO. It is the read-domain counterpart of the write-pointer/full block.
- Synchronizes the write domain's Gray write pointer into rclk internally. It maintains the binary read address and the Gray read pointer, which is exported to the write domain.
- Generates registered empty, almost-empty and fill-level outputs.
- Sits between the FIFO memory read port and the downstream packet parser.

Parameters:
- ADDRSIZE, 4: address width. FIFO depth = 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits.
- AE_THRESH, 2: ralmost_empty asserts when the level is at or below this value. Legal range 0..2^ADDRSIZE.

Ports:
- rclk, input, 1: read clock. All logic is on the rising edge.
- rrst, input, 1: asynchronous active-low reset.
- rinc, input, 1: read request. One word is consumed per cycle when rempty=0.
- rwptr, input, ADDRSIZE+1: Gray write pointer from the wclk domain. Unsynchronized.
- raddr, output, ADDRSIZE: memory read address. Equals rbin[ADDRSIZE-1:0].
- rptr, output reg, ADDRSIZE+1: Gray read pointer, registered, sent to the write domain.
- rempty, output reg, 1: FIFO empty.
- ralmost_empty, output reg, 1: registered (level <= AE_THRESH).
- rlevel, output reg, ADDRSIZE+1: words available, range 0..2^ADDRSIZE.

Behaviour:
- Reset (rrst=0, asynchronous):
  - rbin=0, rptr=0, rlevel=0.
  - rempty=1, ralmost_empty=1.
  - All synchronizer stages cleared to 0.
  - Applies immediately, regardless of any read in progress.
- Synchronizer: rwptr passes through 2 rclk flops to give rq2_wptr. rwptr is never used combinationally.
- Pointer advance:
  - rbinnext = rbin + (rinc & ~rempty).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Both rbin and rptr register on the same edge.
  - A read while rempty=1 is ignored. The pointer holds and there is no underflow.
- Empty:
  - rempty <= (rgraynext == rq2_wptr).
  - Registered, so it asserts on the same edge that consumes the last word.
- Level:
  - Convert rq2_wptr from Gray to binary as wbin_s. Use an XOR-prefix chain, MSB first.
  - rlevel <= wbin_s - rbinnext, modulo 2^(ADDRSIZE+1). Unsigned, ADDRSIZE+1 bits.
  - ralmost_empty <= (wbin_s - rbinnext) <= AE_THRESH.
  - Both update on the same edge as rempty, so all three flags are mutually consistent every cycle.
- Latency:
  - A stable change on rwptr is reflected in rempty, rlevel and ralmost_empty on the 3rd rclk edge: 2 sync stages plus 1 output register.
  - A consumed read shows in raddr and rptr on the next edge.
- Memory data: read combinationally at raddr by the memory. This block owns no data path.
- Wrap-around:
  - raddr wraps 2^ADDRSIZE-1 -> 0.
  - The pointer MSB toggles each lap, so full vs empty stays distinguishable.
  - rlevel = 2^ADDRSIZE when full.
- Simultaneous events:
  - A read and a newly synchronized write pointer on the same edge are both accounted for in rbinnext and wbin_s.
  - The flags use next-state values, so there is no one-cycle false empty.
- Conservatism: the level may lag actual writes. The block must never report more words than are actually present.

Optional Feature:
- Macro: RPTR_SYNC3_EN.
- Defined: the synchronizer is 3 flops. Write-to-flag latency becomes 4 rclk edges. Use for high-frequency rclk.
- Undefined: 2-flop synchronizer, 3-edge latency as specified above.
- Read-path latency and all other behaviour are unchanged in both cases.

Test Plan:
- Reset: assert rrst=0 mid-stream with rlevel=5. Expect immediately rempty=1, ralmost_empty=1, rptr=0, raddr=0, rlevel=0. Expect those values to hold after release.
- Underflow: rwptr=0, rinc=1 for 8 cycles. Expect raddr=0, rptr=0 and rempty=1 throughout.
- Fill/drain: at edge 0, step rwptr to gray(3)=5'b00010. Expect:
  - At edge 3: rempty=0, rlevel=3, ralmost_empty=0.
  - Then rinc=1 for 3 cycles: raddr steps 1, 2, 3.
  - On the 3rd read edge: rempty=1, rlevel=0.
- Almost-empty boundary, AE_THRESH=2: with rlevel=4, read 2 words. Expect ralmost_empty to rise on the edge where rlevel becomes 2. Expect it to stay 1 at levels 1 and 0.
- Full and wrap:
  - rbin=0, rwptr=gray(16)=5'b11000. Expect rlevel=16, rempty=0.
  - Read 16 words. Expect raddr to wrap 15 -> 0, rptr=5'b11000, rempty=1.
  - Then rwptr=gray(20). Expect rlevel=4 after 3 edges.
- Concurrent read and write: while rlevel=1, assert rinc=1 on the same edge that a new rwptr value (+1) reaches rq2_wptr. Expect rempty to stay 0, rlevel=1, and no empty glitch. Rerun the same scenarios with RPTR_SYNC3_EN defined and check for 4-edge latency.
